sdram_responder: RTL and testbench

SDRAM_RESPONDER -- requirements
Module: sdram_responder

---
 rtl/sdram_pkg.sv | 35 +++
 rtl/sdram_read_pipe.sv | 48 ++++
 rtl/sdram_responder.sv | 172 +++++++++++++++++
 tb/tb_sdram_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, bus widths and command decode helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sdram_pkg;

    localparam int DQ_W      = 16;
    localparam int ADDR_W    = 13;
    localparam int BA_W      = 2;
    localparam int NUM_BANKS = 4;
    localparam int AP_BIT    = 10;   // all-banks flag on PRECHARGE

    // Encodings are {RAS_N, CAS_N, WE_N} with CS_N low.
    typedef enum logic [2:0] {
        CMD_NOP       = 3'b111,
        CMD_ACTIVE    = 3'b011,
        CMD_READ      = 3'b101,
        CMD_WRITE     = 3'b100,
        CMD_PRECHARGE = 3'b010
    } sdram_cmd_e;

    // Deselect and every unlisted strobe pattern collapse to NOP.
    function automatic sdram_cmd_e decode_cmd(input logic cs_n, input logic [2:0] rcw);
        if (cs_n) begin
            return CMD_NOP;
        end
        case (rcw)
            3'b011:  return CMD_ACTIVE;
            3'b101:  return CMD_READ;
            3'b100:  return CMD_WRITE;
            3'b010:  return CMD_PRECHARGE;
            default: return CMD_NOP;
        endcase
    endfunction

endpackage

// File: rtl/sdram_read_pipe.sv
// Read-data delay line: valid+data shift register, DEPTH stages.
// Latency: a word loaded at edge E is presented from edge E+DEPTH-1 for one cycle.
// Backpressure: none; one slot per cycle, back-to-back words never merge.
module sdram_read_pipe #(
    parameter int DEPTH = 2,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    output logic [W-1:0] out_dat
);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [W-1:0]     dat_q [DEPTH];
    logic [W-1:0]     dat_d [DEPTH];

    // Shift every stage one slot toward the output each cycle.
    always_comb begin
        vld_d[0] = in_vld;
        dat_d[0] = in_dat;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    // Stage registers; reset discards any word still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_dat = dat_q[DEPTH-1];

endmodule

// File: rtl/sdram_responder.sv
// Behavioural SDRAM device model (4 banks, BL=1) with optional protocol checker (SDRAM_RESP_CHECK_EN).
// Latency: WRITE stored at its edge; READ word on DQ_Out from edge READ+CAS_LAT-1, captured at READ+CAS_LAT.
// Backpressure: none; commands accepted every cycle, illegal accesses dropped (and flagged if checking).
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 7,
    parameter int CAS_LAT  = 2,
    parameter int T_RCD    = 3
) (
    input  logic              CLK,
    input  logic              Reset_N,
    input  logic              DRAM_CS_N,
    input  logic              DRAM_RAS_N,
    input  logic              DRAM_CAS_N,
    input  logic              DRAM_WE_N,
    input  logic [BA_W-1:0]   DRAM_BA,
    input  logic [ADDR_W-1:0] DRAM_ADDR,
    input  logic              DRAM_LDQM,
    input  logic              DRAM_UDQM,
    input  logic [DQ_W-1:0]   DQ_In,
    output logic [DQ_W-1:0]   DQ_Out,
    output logic              DQ_OE,
    output logic              Violation
);

    localparam int MEM_AW    = BA_W + ROW_BITS + COL_BITS;
    localparam int MEM_WORDS = 1 << MEM_AW;

    sdram_cmd_e          cmd;
    logic [BA_W-1:0]     ba;
    logic                bank_open;
    logic                wr_en;
    logic                rd_push;
    logic                collision;
    logic [MEM_AW-1:0]   mem_addr;
    logic [DQ_W-1:0]     rd_dat;
    logic                pipe_vld;
    logic [DQ_W-1:0]     pipe_dat;

    logic [NUM_BANKS-1:0] open_q, open_d;
    logic [ROW_BITS-1:0]  row_q [NUM_BANKS];
    logic [ROW_BITS-1:0]  row_d [NUM_BANKS];

    // Storage is deliberately left out of reset.
    logic [DQ_W-1:0]      mem_q [MEM_WORDS];

    // Only some address bits carry meaning for a given geometry.
    logic addr_unused;
    assign addr_unused = ^DRAM_ADDR;

    assign ba = DRAM_BA;

    // Decode the command and qualify accesses against the bank state.
    always_comb begin
        cmd       = decode_cmd(DRAM_CS_N, {DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N});
        bank_open = open_q[ba];
        mem_addr  = {ba, row_q[ba], DRAM_ADDR[COL_BITS-1:0]};
        rd_dat    = mem_q[mem_addr];
        wr_en     = (cmd == CMD_WRITE) && bank_open;
        rd_push   = (cmd == CMD_READ) && bank_open;
        // Controller driving write data while a read word is on the bus wins the bus.
        collision = (cmd == CMD_WRITE) && pipe_vld;
    end

    // Bank open/row bookkeeping for ACTIVE and PRECHARGE.
    always_comb begin
        open_d = open_q;
        row_d  = row_q;
        case (cmd)
            CMD_ACTIVE: begin
                open_d[ba] = 1'b1;
                row_d[ba]  = DRAM_ADDR[ROW_BITS-1:0];
            end
            CMD_PRECHARGE: begin
                if (DRAM_ADDR[AP_BIT]) begin
                    open_d = '0;
                end else begin
                    open_d[ba] = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Bank state registers; reset closes every bank.
    always_ff @(posedge CLK or negedge Reset_N) begin
        if (!Reset_N) begin
            open_q <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                row_q[b] <= '0;
            end
        end else begin
            open_q <= open_d;
            row_q  <= row_d;
        end
    end

    // Byte-masked write into the array; DQM high protects that byte.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            if (!DRAM_LDQM) begin
                mem_q[mem_addr][7:0] <= DQ_In[7:0];
            end
            if (!DRAM_UDQM) begin
                mem_q[mem_addr][15:8] <= DQ_In[15:8];
            end
        end
    end

    sdram_read_pipe #(
        .DEPTH (CAS_LAT),
        .W     (DQ_W)
    ) u_read_pipe (
        .clk     (CLK),
        .rst_n   (Reset_N),
        .in_vld  (rd_push),
        .in_dat  (rd_dat),
        .out_vld (pipe_vld),
        .out_dat (pipe_dat)
    );

    assign DQ_OE  = pipe_vld && !collision;
    assign DQ_Out = DQ_OE ? pipe_dat : '0;

`ifdef SDRAM_RESP_CHECK_EN
    // Counter value at an edge equals cycles elapsed since the bank's ACTIVE (saturating).
    localparam int                CNT_W  = $clog2(T_RCD + 1);
    localparam logic [CNT_W-1:0]  TRCD_C = CNT_W'(T_RCD);

    logic [CNT_W-1:0] trcd_cnt_q [NUM_BANKS];
    logic [CNT_W-1:0] trcd_cnt_d [NUM_BANKS];
    logic             viol_q, viol_d;
    logic             is_rw;

    // Per-bank tRCD tracking and violation detection.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            trcd_cnt_d[b] = trcd_cnt_q[b];
            if ((cmd == CMD_ACTIVE) && (ba == BA_W'(b))) begin
                trcd_cnt_d[b] = CNT_W'(1);
            end else if (trcd_cnt_q[b] < TRCD_C) begin
                trcd_cnt_d[b] = trcd_cnt_q[b] + CNT_W'(1);
            end
        end
        is_rw  = (cmd == CMD_READ) || (cmd == CMD_WRITE);
        viol_d = (is_rw && !bank_open)
              || (is_rw && bank_open && (trcd_cnt_q[ba] < TRCD_C))
              || ((cmd == CMD_ACTIVE) && bank_open)
              || collision;
    end

    // Checker state; Violation is a registered one-cycle pulse.
    always_ff @(posedge CLK or negedge Reset_N) begin
        if (!Reset_N) begin
            viol_q <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                trcd_cnt_q[b] <= '0;
            end
        end else begin
            viol_q     <= viol_d;
            trcd_cnt_q <= trcd_cnt_d;
        end
    end

    assign Violation = viol_q;
`else
    assign Violation = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_responder.sv
// Scoreboard bench for sdram_responder: directed commands push expected read words and violation cycles.
// Latency: expected word is checked at the edge READ+CAS_LAT that captures it.
// Backpressure: none.
module tb_sdram_responder;

    localparam int CL   = 2;
    localparam int TRCD = 3;
`ifdef SDRAM_RESP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        cs_n, ras_n, cas_n, we_n;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        ldqm, udqm;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        viol;

    typedef struct {
        int          due;
        logic [15:0] dat;
    } exp_t;

    exp_t  sb[$];
    exp_t  ent;
    bit    viol_exp [int];
    int    cyc    = 0;
    int    errors = 0;
    int    checks = 0;

    sdram_responder #(
        .ROW_BITS (4),
        .COL_BITS (7),
        .CAS_LAT  (CL),
        .T_RCD    (TRCD)
    ) dut (
        .CLK        (CLK),
        .Reset_N    (rst_n),
        .DRAM_CS_N  (cs_n),
        .DRAM_RAS_N (ras_n),
        .DRAM_CAS_N (cas_n),
        .DRAM_WE_N  (we_n),
        .DRAM_BA    (ba),
        .DRAM_ADDR  (addr),
        .DRAM_LDQM  (ldqm),
        .DRAM_UDQM  (udqm),
        .DQ_In      (dq_in),
        .DQ_Out     (dq_out),
        .DQ_OE      (dq_oe),
        .Violation  (viol)
    );

    always #5 CLK = ~CLK;

    // Edge counter: at a negedge, cyc is the index of the most recent posedge.
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, req);
        end
    endtask

    task automatic idle_inputs();
        cs_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
        ba = 2'd0; addr = 13'd0; ldqm = 1'b0; udqm = 1'b0; dq_in = 16'h0000;
    endtask

    // Present one command for the next edge; returns that edge's index.
    task automatic issue(input logic cs, input logic [2:0] rcw, input logic [1:0] b,
                         input logic [12:0] a, input logic [15:0] d, input logic l,
                         input logic u, input bit v, output int e);
        @(posedge CLK);
        #1;
        cs_n = cs;
        {ras_n, cas_n, we_n} = rcw;
        ba = b; addr = a; dq_in = d; ldqm = l; udqm = u;
        e = cyc + 1;
        if (v && CHK) viol_exp[e] = 1'b1;
    endtask

    task automatic nop(input int n);
        int e;
        for (int i = 0; i < n; i++) issue(1'b1, 3'b111, 2'd0, 13'd0, 16'h0, 1'b0, 1'b0, 1'b0, e);
    endtask

    task automatic act(input logic [1:0] b, input logic [12:0] row, input bit v);
        int e;
        issue(1'b0, 3'b011, b, row, 16'h0, 1'b0, 1'b0, v, e);
    endtask

    task automatic pre(input logic [1:0] b, input logic all);
        int e;
        issue(1'b0, 3'b010, b, {2'b00, all, 10'd0}, 16'h0, 1'b0, 1'b0, 1'b0, e);
    endtask

    task automatic wr(input logic [1:0] b, input logic [12:0] col, input logic [15:0] d,
                      input logic l, input logic u, input bit v);
        int e;
        issue(1'b0, 3'b100, b, col, d, l, u, v, e);
    endtask

    task automatic rd(input logic [1:0] b, input logic [12:0] col, input bit oe,
                      input logic [15:0] d, input bit v);
        int e;
        exp_t x;
        issue(1'b0, 3'b101, b, col, 16'h0, 1'b0, 1'b0, v, e);
        if (oe) begin
            x.due = e + CL;
            x.dat = d;
            sb.push_back(x);
        end
    endtask

    // Monitor: compares bus activity and Violation against the scoreboard every cycle.
    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL read_missing: no DQ_OE for word %h due at edge %0d", sb[0].dat, sb[0].due);
            void'(sb.pop_front());
        end
        if (dq_oe === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_oe at cycle %0d: DQ_OE=1 data %h, none expected", cyc, dq_out);
            end else begin
                ent = sb.pop_front();
                check("rd_capture_edge", 32'(cyc + 1), 32'(ent.due));
                check("rd_data", {16'h0, dq_out}, {16'h0, ent.dat});
            end
        end else begin
            check("idle_dq_zero", {16'h0, dq_out}, 32'h0);
        end
        check("violation", {31'h0, viol}, {31'h0, viol_exp.exists(cyc)});
    end

    initial begin
        int e;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_oe", {31'h0, dq_oe}, 32'h0);
        check("rst_dq", {16'h0, dq_out}, 32'h0);
        check("rst_viol", {31'h0, viol}, 32'h0);
        @(posedge CLK);
        #1 rst_n = 1'b1;
        nop(2);

        // Basic ACTIVE / tRCD-legal WRITE / READ back.
        act(2'd1, 13'd5, 1'b0);
        nop(2);
        wr(2'd1, 13'h12, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        rd(2'd1, 13'h12, 1'b1, 16'hBEEF, 1'b0);
        nop(2);

        // Byte masks.
        wr(2'd1, 13'h20, 16'h1234, 1'b0, 1'b0, 1'b0);
        wr(2'd1, 13'h20, 16'hABCD, 1'b0, 1'b1, 1'b0);
        rd(2'd1, 13'h20, 1'b1, 16'h12CD, 1'b0);
        wr(2'd1, 13'h20, 16'h5678, 1'b1, 1'b0, 1'b0);
        rd(2'd1, 13'h20, 1'b1, 16'h56CD, 1'b0);
        nop(2);

        // Deselected write and reserved code are NOPs.
        issue(1'b1, 3'b100, 2'd1, 13'h12, 16'h0000, 1'b0, 1'b0, 1'b0, e);
        issue(1'b0, 3'b110, 2'd1, 13'h12, 16'h0000, 1'b0, 1'b0, 1'b0, e);
        rd(2'd1, 13'h12, 1'b1, 16'hBEEF, 1'b0);
        nop(2);

        // Read of a never-activated bank.
        rd(2'd2, 13'h00, 1'b0, 16'h0, 1'b1);
        nop(1);

        // Precharge-all closes every bank.
        act(2'd0, 13'd2, 1'b0);
        act(2'd3, 13'd7, 1'b0);
        pre(2'd0, 1'b1);
        rd(2'd3, 13'h00, 1'b0, 16'h0, 1'b1);
        rd(2'd1, 13'h12, 1'b0, 16'h0, 1'b1);
        nop(2);

        // Back-to-back reads.
        act(2'd0, 13'd9, 1'b0);
        nop(2);
        wr(2'd0, 13'd0, 16'h0001, 1'b0, 1'b0, 1'b0);
        wr(2'd0, 13'd1, 16'h0002, 1'b0, 1'b0, 1'b0);
        wr(2'd0, 13'd2, 16'h0003, 1'b0, 1'b0, 1'b0);
        rd(2'd0, 13'd0, 1'b1, 16'h0001, 1'b0);
        rd(2'd0, 13'd1, 1'b1, 16'h0002, 1'b0);
        rd(2'd0, 13'd2, 1'b1, 16'h0003, 1'b0);
        nop(2);

        // Re-ACTIVE of an open bank replaces the row.
        act(2'd0, 13'd10, 1'b1);
        nop(2);
        wr(2'd0, 13'd0, 16'hA0A0, 1'b0, 1'b0, 1'b0);
        rd(2'd0, 13'd0, 1'b1, 16'hA0A0, 1'b0);
        act(2'd0, 13'd9, 1'b1);
        nop(2);
        rd(2'd0, 13'd0, 1'b1, 16'h0001, 1'b0);
        nop(2);

        // Accesses inside tRCD still execute.
        act(2'd2, 13'd1, 1'b0);
        wr(2'd2, 13'd5, 16'h7777, 1'b0, 1'b0, 1'b1);
        rd(2'd2, 13'd5, 1'b1, 16'h7777, 1'b1);
        nop(2);

        // Single-bank precharge leaves other banks open.
        pre(2'd2, 1'b0);
        rd(2'd0, 13'd0, 1'b1, 16'h0001, 1'b0);
        rd(2'd2, 13'd5, 1'b0, 16'h0, 1'b1);
        nop(2);

        // Write landing on the edge a read word is due.
        rd(2'd0, 13'd1, 1'b0, 16'h0, 1'b0);
        nop(1);
        wr(2'd0, 13'd1, 16'h4242, 1'b0, 1'b0, 1'b1);
        rd(2'd0, 13'd1, 1'b1, 16'h4242, 1'b0);
        nop(2);

        // Reset one cycle after a READ discards the word and closes banks.
        rd(2'd0, 13'd2, 1'b0, 16'h0, 1'b0);
        @(posedge CLK);
        #1;
        rst_n = 1'b0;
        idle_inputs();
        @(negedge CLK);
        check("midrst_oe", {31'h0, dq_oe}, 32'h0);
        check("midrst_dq", {16'h0, dq_out}, 32'h0);
        check("midrst_viol", {31'h0, viol}, 32'h0);
        repeat (2) @(posedge CLK);
        #1 rst_n = 1'b1;
        nop(1);
        rd(2'd0, 13'd2, 1'b0, 16'h0, 1'b1);
        nop(1);
        act(2'd0, 13'd9, 1'b0);
        nop(2);
        rd(2'd0, 13'd2, 1'b1, 16'h0003, 1'b0);
        nop(4);

        @(negedge CLK);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
